alu_seq_core: RTL and testbench



---
 rtl/alu_seq_core.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core -- parametrised sequential ALU with a multi-cycle shift-add
// multiplier, done/err handshake, abortable busy phase and optional flags.
//
// Optional feature macro: ALU_FLAGS_EN
//   defined   : flags = {C,Z,N,V}, registered together with out
//   undefined : flags tied to 4'b0000, no flag logic is built
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   on         enable; 0 freezes every register and the FSM
//   in_sel     [2]=persist [1]=load [0]=clear (clear > load > persist)
//   num1/num2  operand sources, captured on an accepted load
//   out_sel    one-hot op: [6]ADD [5]SUB [4]AND [3]OR [2]XOR [1]NOT(A) [0]MUL
//   final1/2   registered operands A and B
//   out        registered result
//   done       high while the FSM is in DONE
//   err        one-cycle pulse when LOADED sees a zero or multi-hot out_sel
//   flags      {C,Z,N,V} (see macro above)
//   currState  current FSM state (IDLE=00 LOADED=01 BUSY=10 DONE=11)
//   nextState  combinational next state
//
// Handshake: a load is accepted only in IDLE or DONE; the result is valid,
// and done is high, for as long as the FSM sits in DONE. A new load or a
// clear leaves DONE. Loads in LOADED or BUSY are dropped.

module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  output logic [WIDTH-1:0] final1,
  output logic [WIDTH-1:0] final2,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);

  // With flags the accumulator keeps the full double-width product so the
  // carry flag can see the discarded high half.
`ifdef ALU_FLAGS_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOADED = 2'b01,
    BUSY   = 2'b10,
    DONE   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_PERSIST = 2'b00,
    CMD_LOAD    = 2'b01,
    CMD_CLEAR   = 2'b10
  } cmd_t;

  state_t           state;
  state_t           next_state;
  cmd_t             cmd;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mcand;
  logic [ACC_W-1:0] acc_next;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] alu_res;
  logic             op_valid;
  logic             is_mul;
  logic             last_iter;
  logic             load_ok;

  // Priority decode; 000 and any pattern without clear/load is persist.
  always_comb begin
    casez (in_sel)
      3'b??1:  cmd = CMD_CLEAR;
      3'b?10:  cmd = CMD_LOAD;
      default: cmd = CMD_PERSIST;
    endcase
  end

  // x & (x-1) clears the lowest set bit, so zero means at most one bit set.
  assign op_valid  = (out_sel != 7'd0) && ((out_sel & (out_sel - 7'd1)) == 7'd0);
  assign is_mul    = (out_sel == 7'b0000001);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign load_ok   = (cmd == CMD_LOAD) && ((state == IDLE) || (state == DONE));
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;

  // Single-cycle ops; only evaluated when out_sel is one-hot.
  always_comb begin
    alu_res = '0;
    if (out_sel[6])      alu_res = final1 + final2;
    else if (out_sel[5]) alu_res = final1 - final2;
    else if (out_sel[4]) alu_res = final1 & final2;
    else if (out_sel[3]) alu_res = final1 | final2;
    else if (out_sel[2]) alu_res = final1 ^ final2;
    else if (out_sel[1]) alu_res = ~final1;
  end

  always_comb begin
    next_state = state;
    if (on) begin
      if (cmd == CMD_CLEAR) begin
        next_state = IDLE;
      end else if (load_ok) begin
        next_state = LOADED;
      end else begin
        case (state)
          LOADED: begin
            if (!op_valid)   next_state = IDLE;
            else if (is_mul) next_state = BUSY;
            else             next_state = DONE;
          end
          BUSY:    if (last_iter) next_state = DONE;
          default: next_state = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      final1 <= '0;
      final2 <= '0;
      out    <= '0;
      err    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (!on) begin
      err <= 1'b0;
    end else begin
      err   <= 1'b0;
      state <= next_state;
      if (cmd == CMD_CLEAR) begin
        final1 <= '0;
        final2 <= '0;
        out    <= '0;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= '0;
        mplier <= '0;
      end else if (load_ok) begin
        final1 <= num1;
        final2 <= num2;
      end else begin
        case (state)
          LOADED: begin
            if (!op_valid) begin
              err <= 1'b1;
            end else if (is_mul) begin
              cnt    <= '0;
              acc    <= '0;
              mcand  <= ACC_W'(final1);
              mplier <= final2;
            end else begin
              out <= alu_res;
            end
          end
          BUSY: begin
            // One multiplier bit per cycle, LSB first; out only changes
            // on the final iteration so no partial product is visible.
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) out <= acc_next[WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] alu_flags;
  logic [3:0] mul_flags;
  logic [3:0] flags_q;
  logic       c_bit;
  logic       v_bit;

  always_comb begin
    c_bit = 1'b0;
    v_bit = 1'b0;
    if (out_sel[6]) begin
      // MSB carry-out recovered from the operand and sum MSBs.
      c_bit = (final1[WIDTH-1] & final2[WIDTH-1]) |
              ((final1[WIDTH-1] | final2[WIDTH-1]) & ~alu_res[WIDTH-1]);
      v_bit = (final1[WIDTH-1] == final2[WIDTH-1]) &&
              (alu_res[WIDTH-1] != final1[WIDTH-1]);
    end else if (out_sel[5]) begin
      c_bit = (final1 < final2);
      v_bit = (final1[WIDTH-1] != final2[WIDTH-1]) &&
              (alu_res[WIDTH-1] != final1[WIDTH-1]);
    end
    alu_flags = {c_bit, (alu_res == '0), alu_res[WIDTH-1], v_bit};
  end

  assign mul_flags = {(|acc_next[ACC_W-1:WIDTH]), (acc_next[WIDTH-1:0] == '0),
                      acc_next[WIDTH-1], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (on) begin
      if (cmd == CMD_CLEAR)
        flags_q <= 4'b0000;
      else if (!load_ok && (state == LOADED) && op_valid && !is_mul)
        flags_q <= alu_flags;
      else if (!load_ok && (state == BUSY) && last_iter)
        flags_q <= mul_flags;
    end
  end

  assign flags = flags_q;
`else
  assign flags = 4'b0000;
`endif

  assign done      = (state == DONE);
  assign currState = state;
  assign nextState = next_state;

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

  localparam int W = 8;
  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;
  localparam logic [6:0] OP_AND = 7'b0010000;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_XOR = 7'b0000100;
  localparam logic [6:0] OP_NOT = 7'b0000010;
  localparam logic [6:0] OP_MUL = 7'b0000001;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         on;
  logic [2:0]   in_sel;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [6:0]   out_sel;
  logic [W-1:0] final1;
  logic [W-1:0] final2;
  logic [W-1:0] out;
  logic         done;
  logic         err;
  logic [3:0]   flags;
  logic [1:0]   currState;
  logic [1:0]   nextState;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .final1(final1), .final2(final2), .out(out), .done(done),
    .err(err), .flags(flags), .currState(currState), .nextState(nextState)
  );

  // scoreboard
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_out = '0;
  logic [3:0]   exp_flags = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer arithmetic on the operand values, result and
  // flags reduced modulo 2^W. Returns {C,Z,N,V,result}.
  function automatic logic [W+3:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [6:0] sel);
    longint m, ua, ub, sa, sb, r, sr, rm;
    logic c, v, z, n;
    logic [W-1:0] res;
    m  = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (sel)
      OP_ADD: begin r = ua + ub; c = (r >= m); sr = sa + sb; v = (sr >= m / 2) || (sr < -(m / 2)); end
      OP_SUB: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr >= m / 2) || (sr < -(m / 2)); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOT: r = (m - 1) - ua;
      OP_MUL: begin r = ua * ub; c = (r >= m); end
      default: r = 0;
    endcase
    rm  = ((r % m) + m) % m;
    res = rm[W-1:0];
    z   = (rm == 0);
    n   = (rm >= m / 2);
`ifdef ALU_FLAGS_EN
    return {c, z, n, v, res};
`else
    return {4'b0000, res};
`endif
  endfunction

  // driver: load, then persist until done (bounded); checks latency, result,
  // flags, absence of partial results and the final state.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [6:0] sel,
                        input string name);
    logic [W+3:0] e;
    logic [W-1:0] exp_res;
    int lat, exp_lat;
    bit partial;
    e = ref_op(a, b, sel);
    exp_q.push_back(e[W-1:0]);
    exp_lat = (sel == OP_MUL) ? W + 1 : 1;
    in_sel = 3'b010; num1 = a; num2 = b; out_sel = sel;
    step();
    checks++;
    if (currState !== 2'b01 || final1 !== a || final2 !== b) begin
      errors++;
      $display("FAIL %s load: state=%0d A=%h B=%h, expected state=1 A=%h B=%h",
               name, currState, final1, final2, a, b);
    end
    in_sel = 3'b100;
    num1 = W'($urandom);
    num2 = W'($urandom);
    lat = 0;
    partial = 0;
    while (done !== 1'b1 && lat < 4 * W) begin
      step();
      lat++;
      if (done !== 1'b1 && out !== exp_out) partial = 1;
      if (sel == OP_MUL && lat == 1) out_sel = 7'($urandom);
    end
    exp_res = exp_q.pop_front();
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (out !== exp_res) begin
      errors++;
      $display("FAIL %s result: A=%h B=%h out=%h, expected %h", name, a, b, out, exp_res);
    end
    checks++;
    if (flags !== e[W+3:W]) begin
      errors++;
      $display("FAIL %s flags: got %b, expected %b", name, flags, e[W+3:W]);
    end
    checks++;
    if (partial || currState !== 2'b11 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s end: partial=%0d state=%0d err=%b, expected partial=0 state=3 err=0",
               name, partial, currState, err);
    end
    exp_out = exp_res;
    exp_flags = e[W+3:W];
  endtask

  task automatic test_reset();
    checks++;
    if (out !== '0 || final1 !== '0 || final2 !== '0 || flags !== 4'b0 || err !== 1'b0 ||
        done !== 1'b0 || currState !== 2'b00) begin
      errors++;
      $display("FAIL reset: out=%h A=%h B=%h flags=%b err=%b done=%b state=%0d, expected all 0",
               out, final1, final2, flags, err, done, currState);
    end
  endtask

  task automatic test_directed();
    run_op(8'h57, 8'h1A, OP_ADD, "add_57_1a");
    run_op(8'h57, 8'h1A, OP_SUB, "sub_57_1a");
    run_op(8'h02, 8'h04, OP_SUB, "sub_02_04");
    run_op(8'h02, 8'h04, OP_MUL, "mul_02_04");
    run_op(8'h57, 8'h1A, OP_MUL, "mul_57_1a");
    run_op(8'hFF, 8'hFF, OP_MUL, "mul_ff_ff");
    run_op(8'h7F, 8'h01, OP_ADD, "add_ovf");
    run_op(8'h80, 8'h01, OP_SUB, "sub_ovf");
    run_op(8'hFF, 8'h01, OP_ADD, "add_wrap");
    run_op(8'h00, 8'h5A, OP_NOT, "not_zero");
    run_op(8'hF0, 8'h0F, OP_AND, "and_zero");
  endtask

  task automatic test_random();
    logic [6:0] sel;
    for (int i = 0; i < 40; i++) begin
      sel = 7'b1 << $urandom_range(0, 6);
      run_op(W'($urandom), W'($urandom), sel, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(8'h13, 8'h07, OP_MUL, "b2b_mul");
    run_op(8'hC3, 8'h3C, OP_XOR, "b2b_xor");
    run_op(8'hA0, 8'h05, OP_OR, "b2b_or");
    step();
    step();
    checks++;
    if (done !== 1'b1 || out !== exp_out || currState !== 2'b11) begin
      errors++;
      $display("FAIL done_hold: done=%b out=%h state=%0d, expected done=1 out=%h state=3",
               done, out, currState, exp_out);
    end
  endtask

  task automatic test_rst_abort();
    in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = OP_MUL;
    step();
    in_sel = 3'b100;
    repeat (4) step();
    checks++;
    if (currState !== 2'b10) begin
      errors++;
      $display("FAIL rst_abort busy: state=%0d, expected 2", currState);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out !== '0 || final1 !== '0 || final2 !== '0 || flags !== 4'b0 || err !== 1'b0 ||
        done !== 1'b0 || currState !== 2'b00 || nextState !== 2'b00) begin
      errors++;
      $display("FAIL rst_abort: out=%h A=%h B=%h flags=%b state=%0d next=%0d, expected all 0",
               out, final1, final2, flags, currState, nextState);
    end
    step();
    rst = 1'b0;
    repeat (W + 2) step();
    checks++;
    if (out !== '0 || currState !== 2'b00) begin
      errors++;
      $display("FAIL rst_abort after: out=%h state=%0d, expected out=0 state=0", out, currState);
    end
    exp_out = '0;
    exp_flags = '0;
  endtask

  task automatic test_clear_abort();
    run_op(8'h91, 8'h22, OP_ADD, "pre_clear");
    in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = OP_MUL;
    step();
    in_sel = 3'b100;
    repeat (4) step();
    in_sel = 3'b001;
    #1;
    checks++;
    if (nextState !== 2'b00) begin
      errors++;
      $display("FAIL clear next: nextState=%0d, expected 0", nextState);
    end
    step();
    checks++;
    if (out !== '0 || final1 !== '0 || final2 !== '0 || flags !== 4'b0 || currState !== 2'b00 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL clear_abort: out=%h A=%h B=%h flags=%b state=%0d, expected 0",
               out, final1, final2, flags, currState);
    end
    in_sel = 3'b100;
    repeat (W + 2) step();
    checks++;
    if (out !== '0 || currState !== 2'b00) begin
      errors++;
      $display("FAIL clear_abort after: out=%h state=%0d, expected out=0 state=0", out, currState);
    end
    exp_out = '0;
    exp_flags = '0;
  endtask

  task automatic test_freeze();
    logic [W+3:0] e;
    e = ref_op(8'h57, 8'h1A, OP_ADD);
    in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = OP_ADD;
    step();
    on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_sel = 3'($urandom);
      num1 = W'($urandom);
      num2 = W'($urandom);
      step();
      checks++;
      if (currState !== 2'b01 || nextState !== 2'b01 || final1 !== 8'h57 || final2 !== 8'h1A ||
          out !== exp_out || err !== 1'b0) begin
        errors++;
        $display("FAIL freeze: state=%0d next=%0d A=%h B=%h out=%h err=%b, expected 1 1 57 1a %h 0",
                 currState, nextState, final1, final2, out, err, exp_out);
      end
    end
    on = 1'b1;
    in_sel = 3'b100;
    step();
    checks++;
    if (done !== 1'b1 || out !== e[W-1:0] || flags !== e[W+3:W]) begin
      errors++;
      $display("FAIL freeze resume: done=%b out=%h flags=%b, expected 1 %h %b",
               done, out, flags, e[W-1:0], e[W+3:W]);
    end
    exp_out = e[W-1:0];
    exp_flags = e[W+3:W];
  endtask

  task automatic test_err();
    logic [6:0] bad[3];
    logic [6:0] r;
    do r = 7'($urandom); while ($countones(r) == 1);
    bad[0] = 7'b0000011;
    bad[1] = 7'b0000000;
    bad[2] = r;
    for (int i = 0; i < 3; i++) begin
      in_sel = 3'b010; num1 = W'($urandom); num2 = W'($urandom); out_sel = bad[i];
      step();
      in_sel = 3'b100;
      step();
      checks++;
      if (err !== 1'b1 || currState !== 2'b00 || out !== exp_out || flags !== exp_flags ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL err sel=%b: err=%b state=%0d out=%h flags=%b, expected 1 0 %h %b",
                 bad[i], err, currState, out, flags, exp_out, exp_flags);
      end
      step();
      checks++;
      if (err !== 1'b0 || currState !== 2'b00) begin
        errors++;
        $display("FAIL err pulse: err=%b state=%0d, expected err=0 state=0", err, currState);
      end
    end
  endtask

  task automatic test_load_in_busy();
    logic [W-1:0] a, b;
    logic [W+3:0] e;
    int lat;
    a = W'($urandom_range(1, 255));
    b = W'($urandom_range(1, 255));
    e = ref_op(a, b, OP_MUL);
    in_sel = 3'b010; num1 = a; num2 = b; out_sel = OP_MUL;
    step();
    in_sel = 3'b100;
    step();
    lat = 1;
    in_sel = 3'b010; num1 = ~a; num2 = ~b; out_sel = OP_ADD;
    step();
    step();
    lat += 2;
    checks++;
    if (final1 !== a || final2 !== b || currState !== 2'b10) begin
      errors++;
      $display("FAIL load_in_busy: A=%h B=%h state=%0d, expected %h %h 2", final1, final2,
               currState, a, b);
    end
    in_sel = 3'b100;
    while (done !== 1'b1 && lat < 4 * W) begin
      step();
      lat++;
    end
    checks++;
    if (lat != W + 1 || out !== e[W-1:0] || flags !== e[W+3:W]) begin
      errors++;
      $display("FAIL load_in_busy result: lat=%0d out=%h flags=%b, expected %0d %h %b",
               lat, out, flags, W + 1, e[W-1:0], e[W+3:W]);
    end
    exp_out = e[W-1:0];
    exp_flags = e[W+3:W];
  endtask

  initial begin
    rst = 1'b1; on = 1'b1; in_sel = 3'b100; num1 = '0; num2 = '0; out_sel = '0;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_rst_abort();
    test_clear_abort();
    test_freeze();
    test_err();
    test_load_in_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
